// File: rtl/i2c_slave_regs.sv
// I2C target with 2**REG_AW byte registers, auto-incrementing pointer and a write strobe.
// Optional: define I2C_SLAVE_GLITCH_FILTER_EN for a 3-sample filter on synchronised scl/sda.
module i2c_slave_regs #(
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter int unsigned REG_AW   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              scl,
    inout  wire               sda,
    output logic              busy,
    output logic              wr_valid,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_IGNORE
    } state_t;

    state_t            r_state, w_next;
    logic              r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
    logic              r_scl_d, r_sda_d;
    logic              w_scl, w_sda;
    logic              w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [3:0]        r_cnt;
    logic [7:0]        r_shift;
    logic [7:0]        w_byte;
    logic [REG_AW-1:0] r_ptr;
    logic [7:0]        r_regs [2**REG_AW];
    logic              r_sda_oe, r_nack;

    assign sda = r_sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            r_scl_s1 <= scl;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= sda;
            r_sda_s2 <= r_sda_s1;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] r_scl_h, r_sda_h;
    logic       r_scl_f, r_sda_f;

    // Output follows only after three consecutive equal synchronised samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_h <= 2'b11;
            r_sda_h <= 2'b11;
            r_scl_f <= 1'b1;
            r_sda_f <= 1'b1;
        end else begin
            r_scl_h <= {r_scl_h[0], r_scl_s2};
            r_sda_h <= {r_sda_h[0], r_sda_s2};
            if ({r_scl_h, r_scl_s2} == 3'b111)      r_scl_f <= 1'b1;
            else if ({r_scl_h, r_scl_s2} == 3'b000) r_scl_f <= 1'b0;
            if ({r_sda_h, r_sda_s2} == 3'b111)      r_sda_f <= 1'b1;
            else if ({r_sda_h, r_sda_s2} == 3'b000) r_sda_f <= 1'b0;
        end
    end
    assign w_scl = r_scl_f;
    assign w_sda = r_sda_f;
`else
    assign w_scl = r_scl_s2;
    assign w_sda = r_sda_s2;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_byte     = {r_shift[6:0], w_sda};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Byte-level transitions happen on the scl fall that ends the 8th or 9th bit.
    always_comb begin
        w_next = r_state;
        if (w_stop) begin
            w_next = S_IDLE;
        end else if (w_start) begin
            w_next = S_ADDR;
        end else if (w_scl_fall) begin
            case (r_state)
                S_ADDR:     if (r_cnt == 4'd8) w_next = (r_shift[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_IGNORE;
                S_ADDR_ACK: w_next = r_shift[0] ? S_RD : S_PTR;
                S_PTR:      if (r_cnt == 4'd8) w_next = S_PTR_ACK;
                S_PTR_ACK:  w_next = S_WR;
                S_WR:       if (r_cnt == 4'd8) w_next = S_WR_ACK;
                S_WR_ACK:   w_next = S_WR;
                S_RD:       if (r_cnt == 4'd8) w_next = S_RD_ACK;
                S_RD_ACK:   w_next = r_nack ? S_IGNORE : S_RD;
                default:    w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_ptr    <= '0;
            r_sda_oe <= 1'b0;
            r_nack   <= 1'b0;
            for (int i = 0; i < 2**REG_AW; i++) r_regs[i] <= '0;
        end else begin
            wr_valid <= 1'b0;
            if (w_start)     busy <= 1'b1;
            else if (w_stop) busy <= 1'b0;
            // START/STOP abandon any partial byte and free the bus.
            if (w_start || w_stop) begin
                r_cnt    <= '0;
                r_sda_oe <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR, S_PTR, S_WR: begin
                        if (w_scl_rise && r_cnt != 4'd8) begin
                            r_shift <= w_byte;
                            r_cnt   <= r_cnt + 4'd1;
                            if (r_cnt == 4'd7 && r_state == S_PTR) r_ptr <= w_byte[REG_AW-1:0];
                            if (r_cnt == 4'd7 && r_state == S_WR) begin
                                r_regs[r_ptr] <= w_byte;
                                wr_valid      <= 1'b1;
                                wr_addr       <= r_ptr;
                                wr_data       <= w_byte;
                                r_ptr         <= r_ptr + 1'b1;
                            end
                        end else if (w_scl_fall && r_cnt == 4'd8) begin
                            r_cnt    <= '0;
                            r_sda_oe <= (r_state != S_ADDR) || (r_shift[7:1] == DEV_ADDR);
                        end
                    end
                    S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_oe <= 1'b0;
                            if (r_state == S_ADDR_ACK && r_shift[0]) begin
                                r_shift  <= r_regs[r_ptr];
                                r_sda_oe <= ~r_regs[r_ptr][7];
                            end
                        end
                    end
                    S_RD: begin
                        if (w_scl_rise) begin
                            r_cnt <= r_cnt + 4'd1;
                            if (r_cnt == 4'd7) r_ptr <= r_ptr + 1'b1;
                        end else if (w_scl_fall) begin
                            if (r_cnt == 4'd8) begin
                                r_cnt    <= '0;
                                r_sda_oe <= 1'b0;
                            end else begin
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_sda_oe <= ~r_shift[6];
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (w_scl_rise) begin
                            r_nack <= w_sda;
                        end else if (w_scl_fall && !r_nack) begin
                            r_shift  <= r_regs[r_ptr];
                            r_sda_oe <= ~r_regs[r_ptr][7];
                        end
                    end
                    default: r_sda_oe <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: bit-banged I2C master on an open-drain bus.
`timescale 1ns/1ps
module tb_i2c_slave_regs;
    localparam int Q = 100;

    logic       clk;
    logic       reset_n;
    logic       m_scl;
    logic       m_sda;
    wire        sda;
    logic       busy;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    int checks = 0;
    int errors = 0;
    logic [3:0] wr_a_q[$];
    logic [7:0] wr_d_q[$];

    assign sda = m_sda ? 1'bz : 1'b0;
    pullup (sda);

    i2c_slave_regs #(.DEV_ADDR(7'h50), .REG_AW(4)) dut (
        .clk(clk), .reset_n(reset_n), .scl(m_scl), .sda(sda),
        .busy(busy), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_valid) begin
            wr_a_q.push_back(wr_addr);
            wr_d_q.push_back(wr_data);
        end
    end

    task automatic i2c_start();
        m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; m_sda = 1'b0; #Q; m_scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #Q; m_scl = 1'b1; #Q; m_sda = 1'b1; #Q;
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; #Q; m_scl = 1'b1; #(2*Q); m_scl = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; #Q; m_scl = 1'b1; #Q;
        ack = (sda === 1'b0);
        #Q; m_scl = 1'b0; #Q;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            #Q; m_scl = 1'b1; #Q; d[i] = sda; #Q; m_scl = 1'b0; #Q;
        end
        send_bit(nack);
        m_sda = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got %b exp 0", wr_valid); end
        checks++; if (wr_addr !== 4'h0)  begin errors++; $display("FAIL reset_wr_addr got %h exp 0", wr_addr); end
        checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got %h exp 00", wr_data); end
        checks++; if (sda !== 1'b1)      begin errors++; $display("FAIL reset_sda got %b exp 1", sda); end
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_write();
        logic [3:0] acks;
        wr_a_q.delete(); wr_d_q.delete();
        i2c_start();
        write_byte(8'hA0, acks[3]);
        write_byte(8'h03, acks[2]);
        write_byte(8'h11, acks[1]);
        write_byte(8'h22, acks[0]);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy got %b exp 1", busy); end
        i2c_stop(); #Q;
        checks++; if (acks !== 4'b1111) begin errors++; $display("FAIL write_acks got %b exp 1111", acks); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop got %b exp 0", busy); end
        checks++;
        if (wr_a_q.size() != 2) begin
            errors++; $display("FAIL write_count got %0d exp 2", wr_a_q.size());
        end else begin
            checks++;
            if (wr_a_q[0] !== 4'd3 || wr_d_q[0] !== 8'h11) begin
                errors++; $display("FAIL write_first got %h/%h exp 3/11", wr_a_q[0], wr_d_q[0]);
            end
            checks++;
            if (wr_a_q[1] !== 4'd4 || wr_d_q[1] !== 8'h22) begin
                errors++; $display("FAIL write_second got %h/%h exp 4/22", wr_a_q[1], wr_d_q[1]);
            end
        end
    endtask

    task automatic test_wrap();
        logic a;
        logic [7:0] d0, d1;
        wr_a_q.delete(); wr_d_q.delete();
        i2c_start();
        write_byte(8'hA0, a); write_byte(8'h0F, a); write_byte(8'hAA, a); write_byte(8'hBB, a);
        i2c_stop(); #Q;
        checks++;
        if (wr_a_q.size() != 2) begin
            errors++; $display("FAIL wrap_count got %0d exp 2", wr_a_q.size());
        end else begin
            checks++;
            if (wr_a_q[0] !== 4'd15 || wr_d_q[0] !== 8'hAA) begin
                errors++; $display("FAIL wrap_first got %h/%h exp f/aa", wr_a_q[0], wr_d_q[0]);
            end
            checks++;
            if (wr_a_q[1] !== 4'd0 || wr_d_q[1] !== 8'hBB) begin
                errors++; $display("FAIL wrap_second got %h/%h exp 0/bb", wr_a_q[1], wr_d_q[1]);
            end
        end
        i2c_start();
        write_byte(8'hA0, a); write_byte(8'h0F, a);
        i2c_start();
        write_byte(8'hA1, a);
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        i2c_stop(); #Q;
        checks++; if (d0 !== 8'hAA) begin errors++; $display("FAIL wrap_read15 got %h exp aa", d0); end
        checks++; if (d1 !== 8'hBB) begin errors++; $display("FAIL wrap_read0 got %h exp bb", d1); end
    endtask

    task automatic test_read();
        logic [2:0] acks;
        logic [7:0] d0, d1;
        wr_a_q.delete(); wr_d_q.delete();
        i2c_start();
        write_byte(8'hA0, acks[2]); write_byte(8'h03, acks[1]);
        i2c_start();
        write_byte(8'hA1, acks[0]);
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        #Q;
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL read_release got %b exp 1", sda); end
        i2c_stop(); #Q;
        checks++; if (acks !== 3'b111) begin errors++; $display("FAIL read_acks got %b exp 111", acks); end
        checks++; if (d0 !== 8'h11) begin errors++; $display("FAIL read_byte0 got %h exp 11", d0); end
        checks++; if (d1 !== 8'h22) begin errors++; $display("FAIL read_byte1 got %h exp 22", d1); end
        checks++; if (wr_a_q.size() != 0) begin errors++; $display("FAIL read_no_wr got %0d exp 0", wr_a_q.size()); end
    endtask

    task automatic test_mismatch();
        logic a0, a1;
        wr_a_q.delete(); wr_d_q.delete();
        i2c_start();
        write_byte(8'hA2, a0);
        write_byte(8'h55, a1);
        checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL mismatch_addr_ack got %b exp 0", a0); end
        checks++; if (a1 !== 1'b0) begin errors++; $display("FAIL mismatch_data_ack got %b exp 0", a1); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mismatch_busy got %b exp 1", busy); end
        i2c_stop(); #Q;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mismatch_busy_stop got %b exp 0", busy); end
        checks++; if (wr_a_q.size() != 0) begin errors++; $display("FAIL mismatch_no_wr got %0d exp 0", wr_a_q.size()); end
    endtask

    task automatic test_partial_stop();
        logic a;
        logic [7:0] d;
        wr_a_q.delete(); wr_d_q.delete();
        i2c_start();
        write_byte(8'hA0, a); write_byte(8'h05, a); write_byte(8'h5A, a);
        i2c_stop(); #Q;
        i2c_start();
        write_byte(8'hA0, a); write_byte(8'h05, a);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        i2c_stop(); #Q;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL partial_busy got %b exp 0", busy); end
        checks++; if (wr_a_q.size() != 1) begin errors++; $display("FAIL partial_count got %0d exp 1", wr_a_q.size()); end
        i2c_start();
        write_byte(8'hA1, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL partial_readaddr_ack got %b exp 1", a); end
        read_byte(1'b1, d);
        i2c_stop(); #Q;
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL partial_kept got %h exp 5a", d); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        logic [7:0] d;
        logic held, a;
        b = 8'hA0;
        wr_a_q.delete(); wr_d_q.delete();
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; #Q; m_scl = 1'b1; #Q;
        held = (sda === 1'b0);
        reset_n = 1'b0;
        #1;
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL rstmid_ack_held got %b exp 1", held); end
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rstmid_sda got %b exp 1", sda); end
        #Q; m_scl = 1'b0; #Q;
        reset_n = 1'b1;
        #Q;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        checks++; if (wr_addr !== 4'h0) begin errors++; $display("FAIL rstmid_wr_addr got %h exp 0", wr_addr); end
        write_byte(8'h03, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL rstmid_idle_ack got %b exp 0", a); end
        i2c_stop(); #Q;
        checks++; if (wr_a_q.size() != 0) begin errors++; $display("FAIL rstmid_no_wr got %0d exp 0", wr_a_q.size()); end
        i2c_start();
        write_byte(8'hA0, a); write_byte(8'h00, a);
        i2c_start();
        write_byte(8'hA1, a);
        for (int i = 0; i < 16; i++) begin
            read_byte(i == 15, d);
            checks++;
            if (d !== 8'h00) begin errors++; $display("FAIL rstmid_reg%0d got %h exp 00", i, d); end
        end
        i2c_stop(); #Q;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_write();
        test_wrap();
        test_read();
        test_mismatch();
        test_partial_stop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
